// File: rtl/dac_ddr_framer_if.sv
// Sample, configuration and framed-output bundle of the DDR DAC framer.
// The bench or upstream logic drives the master side; the framer is the slave.
interface dac_ddr_framer_if #(
    parameter int DATA_W  = 16,
    parameter int N_PAIRS = 1
);

    localparam int NCH = 2 * N_PAIRS;
    localparam int OW  = N_PAIRS * (DATA_W + 2);

    logic [NCH*DATA_W-1:0] din;
    logic                  din_valid;
    logic                  cfg_we;
    logic                  cfg_re;
    logic [7:0]            cfg_addr;
    logic [15:0]           cfg_data;
    logic                  cfg_commit;
    logic [15:0]           cfg_rdata;
    logic [OW-1:0]         d1_out;
    logic [OW-1:0]         d2_out;
    logic [NCH-1:0]        sat_out;
    logic [15:0]           underrun_cnt;

    modport master (
        output din, din_valid,
        output cfg_we, cfg_re, cfg_addr, cfg_data, cfg_commit,
        input  cfg_rdata, d1_out, d2_out, sat_out, underrun_cnt
    );

    modport slave (
        input  din, din_valid,
        input  cfg_we, cfg_re, cfg_addr, cfg_data, cfg_commit,
        output cfg_rdata, d1_out, d2_out, sat_out, underrun_cnt
    );

endinterface

// File: rtl/dac_ddr_framer.sv
// DDR-LVDS DAC framer: per-channel source select, offset with saturation,
// D1/D2 word framing, shadowed configuration and status counters.
module dac_ddr_framer #(
    parameter int DATA_W           = 16,
    parameter int N_PAIRS          = 1,
    parameter bit HOLD_ON_UNDERRUN = 1'b1
) (
    input  logic            clkD,
    input  logic            rst_in,
    dac_ddr_framer_if.slave bus
);

    localparam int NCH = 2 * N_PAIRS;
    localparam int SW  = DATA_W + 1;
    localparam int FW  = DATA_W + 2;

    localparam logic [1:0] MODE_LIVE  = 2'd0;
    localparam logic [1:0] MODE_CONST = 2'd1;
    localparam logic [1:0] MODE_RAMP  = 2'd2;
    localparam logic [1:0] MODE_MID   = 2'd3;

    localparam logic [1:0] FRAME_D1 = 2'b01;
    localparam logic [1:0] FRAME_D2 = 2'b10;

    localparam logic [DATA_W-1:0] DMAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] DMIN = {1'b1, {(DATA_W-1){1'b0}}};

    localparam logic [7:0] ADDR_URUN = 8'h80;
    localparam logic [7:0] ADDR_SAT  = 8'h81;

    logic [1:0]        r_sh_mode  [NCH];
    logic [DATA_W-1:0] r_sh_off   [NCH];
    logic [DATA_W-1:0] r_sh_const [NCH];
    logic [DATA_W-1:0] r_sh_step  [NCH];

    logic [1:0]        r_ac_mode  [NCH];
    logic [DATA_W-1:0] r_ac_off   [NCH];
    logic [DATA_W-1:0] r_ac_const [NCH];
    logic [DATA_W-1:0] r_ac_step  [NCH];

    logic [1:0]        w_nx_mode  [NCH];
    logic [DATA_W-1:0] w_nx_off   [NCH];
    logic [DATA_W-1:0] w_nx_const [NCH];
    logic [DATA_W-1:0] w_nx_step  [NCH];

    logic [DATA_W-1:0] r_acc      [NCH];
    logic [DATA_W-1:0] r_last     [NCH];
    logic [SW-1:0]     r_s1_sum   [NCH];

    logic [DATA_W-1:0] w_src      [NCH];
    logic [SW-1:0]     w_sum      [NCH];
    logic [DATA_W-1:0] w_sat_data [NCH];
    logic [NCH-1:0]    w_ovf;

    logic [FW*N_PAIRS-1:0] r_d1;
    logic [FW*N_PAIRS-1:0] r_d2;
    logic [NCH-1:0]        r_sat;
    logic [15:0]           r_urun;
    logic [15:0]           r_rdata;
    logic [15:0]           w_rd;

    logic       w_ch_acc;
    logic [3:0] w_k;
    logic [2:0] w_r;
    logic       w_clr_urun;
    logic       w_clr_sat;
    logic       w_any_live;
    logic       w_urun_inc;

    assign w_ch_acc   = ~bus.cfg_addr[7];
    assign w_k        = bus.cfg_addr[6:3];
    assign w_r        = bus.cfg_addr[2:0];
    assign w_clr_urun = bus.cfg_we && (bus.cfg_addr == ADDR_URUN);
    assign w_clr_sat  = bus.cfg_we && (bus.cfg_addr == ADDR_SAT);
    assign w_urun_inc = !bus.din_valid && w_any_live
                        && (r_urun != 16'hFFFF);

    // Post-write shadow image; a commit copies this so a same-cycle
    // write is part of the committed set.
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            w_nx_mode[k]  = r_sh_mode[k];
            w_nx_off[k]   = r_sh_off[k];
            w_nx_const[k] = r_sh_const[k];
            w_nx_step[k]  = r_sh_step[k];
            if (bus.cfg_we && w_ch_acc && (w_k == 4'(k))) begin
                case (w_r)
                    3'd0: w_nx_mode[k]  = bus.cfg_data[1:0];
                    3'd1: w_nx_off[k]   = bus.cfg_data[DATA_W-1:0];
                    3'd2: w_nx_const[k] = bus.cfg_data[DATA_W-1:0];
                    3'd3: w_nx_step[k]  = bus.cfg_data[DATA_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        w_rd = '0;
        if (bus.cfg_addr == ADDR_URUN) begin
            w_rd = r_urun;
        end else if (bus.cfg_addr == ADDR_SAT) begin
            w_rd[NCH-1:0] = r_sat;
        end else if (w_ch_acc) begin
            for (int k = 0; k < NCH; k++) begin
                if (w_k == 4'(k)) begin
                    case (w_r)
                        3'd0: w_rd[1:0]        = r_sh_mode[k];
                        3'd1: w_rd[DATA_W-1:0] = r_sh_off[k];
                        3'd2: w_rd[DATA_W-1:0] = r_sh_const[k];
                        3'd3: w_rd[DATA_W-1:0] = r_sh_step[k];
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        w_any_live = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (r_ac_mode[k] == MODE_LIVE) w_any_live = 1'b1;
        end
    end

    // Stage 1: source select and offset add in DATA_W+1 bits
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            w_src[k] = '0;
            case (r_ac_mode[k])
                MODE_LIVE: begin
                    if (bus.din_valid)
                        w_src[k] = bus.din[k*DATA_W +: DATA_W];
                    else if (HOLD_ON_UNDERRUN)
                        w_src[k] = r_last[k];
                end
                MODE_CONST: w_src[k] = r_ac_const[k];
                MODE_RAMP:  w_src[k] = r_acc[k];
                default:    w_src[k] = '0;
            endcase
            if (r_ac_mode[k] == MODE_MID)
                w_sum[k] = '0;
            else
                w_sum[k] = {w_src[k][DATA_W-1], w_src[k]}
                         + {r_ac_off[k][DATA_W-1], r_ac_off[k]};
        end
    end

    // Stage 2: overflow shows as disagreement of the two top sum bits
    always_comb begin
        w_ovf = '0;
        for (int k = 0; k < NCH; k++) begin
            w_ovf[k] = r_s1_sum[k][SW-1] ^ r_s1_sum[k][SW-2];
            if (!w_ovf[k])
                w_sat_data[k] = r_s1_sum[k][DATA_W-1:0];
            else if (r_s1_sum[k][SW-1])
                w_sat_data[k] = DMIN;
            else
                w_sat_data[k] = DMAX;
        end
    end

    always_ff @(posedge clkD or posedge rst_in) begin
        if (rst_in) begin
            for (int k = 0; k < NCH; k++) begin
                r_sh_mode[k]  <= MODE_LIVE;
                r_sh_off[k]   <= '0;
                r_sh_const[k] <= '0;
                r_sh_step[k]  <= '0;
                r_ac_mode[k]  <= MODE_LIVE;
                r_ac_off[k]   <= '0;
                r_ac_const[k] <= '0;
                r_ac_step[k]  <= '0;
                r_acc[k]      <= '0;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                r_sh_mode[k]  <= w_nx_mode[k];
                r_sh_off[k]   <= w_nx_off[k];
                r_sh_const[k] <= w_nx_const[k];
                r_sh_step[k]  <= w_nx_step[k];
                if (bus.cfg_commit) begin
                    r_ac_mode[k]  <= w_nx_mode[k];
                    r_ac_off[k]   <= w_nx_off[k];
                    r_ac_const[k] <= w_nx_const[k];
                    r_ac_step[k]  <= w_nx_step[k];
                end
                if (bus.cfg_commit && (w_nx_mode[k] == MODE_RAMP)
                    && (r_ac_mode[k] != MODE_RAMP))
                    r_acc[k] <= '0;
                else
                    r_acc[k] <= r_acc[k] + r_ac_step[k];
            end
        end
    end

    always_ff @(posedge clkD or posedge rst_in) begin
        if (rst_in) begin
            for (int k = 0; k < NCH; k++) begin
                r_last[k]   <= '0;
                r_s1_sum[k] <= '0;
            end
            for (int p = 0; p < N_PAIRS; p++) begin
                r_d1[p*FW +: FW] <= {FRAME_D1, {DATA_W{1'b0}}};
                r_d2[p*FW +: FW] <= {FRAME_D2, {DATA_W{1'b0}}};
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (bus.din_valid)
                    r_last[k] <= bus.din[k*DATA_W +: DATA_W];
                r_s1_sum[k] <= w_sum[k];
            end
            for (int p = 0; p < N_PAIRS; p++) begin
                r_d1[p*FW +: FW] <= {FRAME_D1, w_sat_data[2*p]};
                r_d2[p*FW +: FW] <= {FRAME_D2, w_sat_data[2*p+1]};
            end
        end
    end

    // Status: a clear in the same cycle as a count or a set wins
    always_ff @(posedge clkD or posedge rst_in) begin
        if (rst_in) begin
            r_urun  <= '0;
            r_sat   <= '0;
            r_rdata <= '0;
        end else begin
            if (w_clr_urun)
                r_urun <= '0;
            else if (w_urun_inc)
                r_urun <= r_urun + 16'd1;
            if (w_clr_sat)
                r_sat <= '0;
            else
                r_sat <= r_sat | w_ovf;
            if (bus.cfg_re)
                r_rdata <= w_rd;
        end
    end

    assign bus.d1_out       = r_d1;
    assign bus.d2_out       = r_d2;
    assign bus.sat_out      = r_sat;
    assign bus.underrun_cnt = r_urun;
    assign bus.cfg_rdata    = r_rdata;

endmodule

// File: tb/tb_dac_ddr_framer.sv
// Bench for dac_ddr_framer: two instances (hold / no-hold on underrun)
// share stimulus and are compared against a sample-level reference model.
module tb_dac_ddr_framer;

    logic clk = 1'b0;
    logic rst_in;

    always #5 clk = ~clk;

    dac_ddr_framer_if #(.DATA_W(16), .N_PAIRS(2)) ifa ();
    dac_ddr_framer_if #(.DATA_W(16), .N_PAIRS(2)) ifb ();

    assign ifb.din        = ifa.din;
    assign ifb.din_valid  = ifa.din_valid;
    assign ifb.cfg_we     = ifa.cfg_we;
    assign ifb.cfg_re     = ifa.cfg_re;
    assign ifb.cfg_addr   = ifa.cfg_addr;
    assign ifb.cfg_data   = ifa.cfg_data;
    assign ifb.cfg_commit = ifa.cfg_commit;

    dac_ddr_framer #(
        .DATA_W(16), .N_PAIRS(2), .HOLD_ON_UNDERRUN(1'b1)
    ) u_a (
        .clkD(clk), .rst_in(rst_in), .bus(ifa)
    );

    dac_ddr_framer #(
        .DATA_W(16), .N_PAIRS(2), .HOLD_ON_UNDERRUN(1'b0)
    ) u_b (
        .clkD(clk), .rst_in(rst_in), .bus(ifb)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model; index h: 0 = holding instance, 1 = zeroing instance
    logic [1:0]  sh_mode [4], ac_mode [4];
    logic [15:0] sh_off [4], sh_const [4], sh_step [4];
    logic [15:0] ac_off [4], ac_const [4], ac_step [4];
    logic [15:0] acc [4], last [4];
    logic [15:0] pend [2][4], out [2][4];
    logic [3:0]  pcl [2], sat [2];
    logic [15:0] urun;
    logic [15:0] rdat [2];

    function automatic int sx(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            sh_mode[k] = 0; sh_off[k] = 0; sh_const[k] = 0; sh_step[k] = 0;
            ac_mode[k] = 0; ac_off[k] = 0; ac_const[k] = 0; ac_step[k] = 0;
            acc[k] = 0; last[k] = 0;
            for (int h = 0; h < 2; h++) begin
                pend[h][k] = 0; out[h][k] = 0;
            end
        end
        for (int h = 0; h < 2; h++) begin
            pcl[h] = 0; sat[h] = 0; rdat[h] = 0;
        end
        urun = 0;
    endtask

    function automatic logic [15:0] readval(input int h);
        logic [7:0] a;
        int kk;
        a = ifa.cfg_addr;
        kk = int'(a[6:3]);
        if (a == 8'h80) return urun;
        if (a == 8'h81) return {12'd0, sat[h]};
        if (a[7] || kk >= 4) return 16'd0;
        case (a[2:0])
            3'd0: return {14'd0, sh_mode[kk]};
            3'd1: return sh_off[kk];
            3'd2: return sh_const[kk];
            3'd3: return sh_step[kk];
            default: return 16'd0;
        endcase
    endfunction

    task automatic model_edge();
        logic [15:0] rv [2];
        logic [15:0] dk;
        logic [7:0]  a;
        bit clr80, clr81, any_live;
        int src, s, kk;
        a = ifa.cfg_addr;
        for (int h = 0; h < 2; h++) rv[h] = readval(h);
        clr80 = ifa.cfg_we && a == 8'h80;
        clr81 = ifa.cfg_we && a == 8'h81;
        for (int h = 0; h < 2; h++) begin
            for (int k = 0; k < 4; k++) out[h][k] = pend[h][k];
            sat[h] = clr81 ? 4'd0 : (sat[h] | pcl[h]);
        end
        any_live = 0;
        for (int k = 0; k < 4; k++) if (ac_mode[k] == 2'd0) any_live = 1;
        for (int h = 0; h < 2; h++) begin
            for (int k = 0; k < 4; k++) begin
                dk = ifa.din[k*16 +: 16];
                pcl[h][k] = 1'b0;
                case (ac_mode[k])
                    2'd0: src = ifa.din_valid ? sx(dk)
                              : (h == 0 ? sx(last[k]) : 0);
                    2'd1: src = sx(ac_const[k]);
                    2'd2: src = sx(acc[k]);
                    default: src = 0;
                endcase
                if (ac_mode[k] == 2'd3) begin
                    pend[h][k] = 16'd0;
                end else begin
                    s = src + sx(ac_off[k]);
                    if (s > 32767) begin
                        s = 32767; pcl[h][k] = 1'b1;
                    end else if (s < -32768) begin
                        s = -32768; pcl[h][k] = 1'b1;
                    end
                    pend[h][k] = 16'(s);
                end
            end
            if (ifa.cfg_re) rdat[h] = rv[h];
        end
        if (clr80) urun = 0;
        else if (!ifa.din_valid && any_live && urun != 16'hFFFF)
            urun = urun + 16'd1;
        for (int k = 0; k < 4; k++)
            if (ifa.din_valid) last[k] = ifa.din[k*16 +: 16];
        kk = int'(a[6:3]);
        if (ifa.cfg_we && !a[7] && kk < 4) begin
            case (a[2:0])
                3'd0: sh_mode[kk]  = ifa.cfg_data[1:0];
                3'd1: sh_off[kk]   = ifa.cfg_data;
                3'd2: sh_const[kk] = ifa.cfg_data;
                3'd3: sh_step[kk]  = ifa.cfg_data;
                default: ;
            endcase
        end
        for (int k = 0; k < 4; k++) begin
            if (ifa.cfg_commit && ac_mode[k] != 2'd2 && sh_mode[k] == 2'd2)
                acc[k] = 16'd0;
            else
                acc[k] = acc[k] + ac_step[k];
            if (ifa.cfg_commit) begin
                ac_mode[k] = sh_mode[k]; ac_off[k] = sh_off[k];
                ac_const[k] = sh_const[k]; ac_step[k] = sh_step[k];
            end
        end
    endtask

    task automatic check_all();
        logic [35:0] e1 [2], e2 [2];
        for (int h = 0; h < 2; h++) begin
            e1[h] = '0; e2[h] = '0;
            for (int p = 0; p < 2; p++) begin
                e1[h][p*18 +: 18] = {2'b01, out[h][2*p]};
                e2[h][p*18 +: 18] = {2'b10, out[h][2*p+1]};
            end
        end
        chk("a_d1", ifa.d1_out, e1[0]);
        chk("a_d2", ifa.d2_out, e2[0]);
        chk("a_sat", ifa.sat_out, sat[0]);
        chk("a_urun", ifa.underrun_cnt, urun);
        chk("a_rdata", ifa.cfg_rdata, rdat[0]);
        chk("b_d1", ifb.d1_out, e1[1]);
        chk("b_d2", ifb.d2_out, e2[1]);
        chk("b_sat", ifb.sat_out, sat[1]);
        chk("b_urun", ifb.underrun_cnt, urun);
        chk("b_rdata", ifb.cfg_rdata, rdat[1]);
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst_in) model_reset();
        else model_edge();
        #1;
        check_all();
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d,
                      input logic c);
        ifa.cfg_we = 1'b1; ifa.cfg_addr = a;
        ifa.cfg_data = d; ifa.cfg_commit = c;
        cyc();
        ifa.cfg_we = 1'b0; ifa.cfg_commit = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a);
        ifa.cfg_re = 1'b1; ifa.cfg_addr = a;
        cyc();
        ifa.cfg_re = 1'b0;
    endtask

    task automatic set_din(input logic [15:0] c0, input logic [15:0] c1,
                           input logic [15:0] c2, input logic [15:0] c3);
        ifa.din = {c3, c2, c1, c0};
        ifa.din_valid = 1'b1;
    endtask

    initial begin
        logic [7:0] a;
        rst_in = 1'b1;
        ifa.din = '0; ifa.din_valid = 1'b0;
        ifa.cfg_we = 1'b0; ifa.cfg_re = 1'b0; ifa.cfg_addr = '0;
        ifa.cfg_data = '0; ifa.cfg_commit = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_d1", ifa.d1_out, 36'h400010000);
        chk("rst_d2", ifa.d2_out, 36'h800020000);
        cyc(); cyc();
        rst_in = 1'b0;

        set_din(16'h1234, 16'hFEDC, 16'h0000, 16'h0000);
        cyc(); cyc();
        chk("live_d1", ifa.d1_out[17:0], 18'h11234);
        chk("live_d2", ifa.d2_out[17:0], 18'h2FEDC);

        wr(8'h01, 16'h0010, 1'b1);
        set_din(16'h7FF8, 16'hFEDC, 16'h0000, 16'h0000);
        cyc(); cyc();
        chk("sat_hi_data", ifa.d1_out[15:0], 16'h7FFF);
        chk("sat_hi_flag", ifa.sat_out[0], 1'b1);
        set_din(16'h0000, 16'hFEDC, 16'h0000, 16'h0000);
        cyc(); cyc();
        wr(8'h81, 16'h0000, 1'b0);
        chk("sat_clear", ifa.sat_out, 4'b0000);
        wr(8'h01, 16'hFFFF, 1'b1);
        set_din(16'h8000, 16'hFEDC, 16'h0000, 16'h0000);
        cyc(); cyc();
        chk("sat_lo_data", ifa.d1_out[15:0], 16'h8000);
        chk("sat_lo_flag", ifa.sat_out[0], 1'b1);

        wr(8'h01, 16'h0000, 1'b1);
        wr(8'h80, 16'h0000, 1'b0);
        set_din(16'h0100, 16'hFEDC, 16'h0000, 16'h0000);
        cyc();
        ifa.din_valid = 1'b0;
        ifa.din = '0;
        for (int i = 0; i < 5; i++) cyc();
        chk("urun_cnt", ifa.underrun_cnt, 16'd5);
        chk("urun_hold", ifa.d1_out[15:0], 16'h0100);
        chk("urun_zero", ifb.d1_out[15:0], 16'h0000);

        set_din(16'h0555, 16'h0000, 16'h0000, 16'h0000);
        wr(8'h00, 16'h0001, 1'b0);
        wr(8'h02, 16'h0AAA, 1'b0);
        cyc(); cyc();
        chk("shadow_only", ifa.d1_out[15:0], 16'h0555);
        rd(8'h00);
        chk("rd_mode0", ifa.cfg_rdata, 16'h0001);
        rd(8'h02);
        chk("rd_const0", ifa.cfg_rdata, 16'h0AAA);
        ifa.cfg_commit = 1'b1;
        cyc();
        ifa.cfg_commit = 1'b0;
        cyc();
        chk("commit_e2", ifa.d1_out[15:0], 16'h0555);
        cyc();
        chk("commit_e3", ifa.d1_out[15:0], 16'h0AAA);

        wr(8'h0B, 16'h4000, 1'b0);
        wr(8'h08, 16'h0002, 1'b1);
        cyc();
        for (int i = 0; i < 5; i++) begin
            logic [15:0] ev;
            ev = 16'(i * 32'h4000);
            cyc();
            chk("ramp_ch1", ifa.d2_out[15:0], ev);
        end
        chk("ramp_nosat", ifa.sat_out[1], 1'b0);

        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 4; k++) ifa.din[k*16 +: 16] = 16'($urandom);
            ifa.din_valid = ($urandom_range(0, 4) != 0);
            ifa.cfg_we = ($urandom_range(0, 3) == 0);
            ifa.cfg_re = !ifa.cfg_we && ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 19))
                0: a = 8'h80;
                1: a = 8'h81;
                default: a = {1'b0, 4'($urandom_range(0, 5)),
                              3'($urandom_range(0, 4))};
            endcase
            ifa.cfg_addr = a;
            ifa.cfg_data = 16'($urandom);
            ifa.cfg_commit = ($urandom_range(0, 7) == 0);
            cyc();
        end
        ifa.cfg_we = 1'b0; ifa.cfg_re = 1'b0; ifa.cfg_commit = 1'b0;

        set_din(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        cyc();
        #2;
        rst_in = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("arst_d1", ifa.d1_out, 36'h400010000);
        chk("arst_d2", ifa.d2_out, 36'h800020000);
        cyc();
        rst_in = 1'b0;
        rd(8'h01);
        chk("arst_rd_off0", ifa.cfg_rdata, 16'h0000);
        rd(8'h80);
        chk("arst_rd_urun", ifa.cfg_rdata, 16'h0000);
        set_din(16'h1357, 16'h0000, 16'h2468, 16'h0000);
        cyc();
        set_din(16'h0000, 16'h0000, 16'h0000, 16'h0000);
        cyc();
        chk("arst_restart", ifa.d1_out[35:18], 18'h12468);
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
